// File: rtl/exc_pipe_pkg.sv
// rtl/exc_pipe_pkg.sv - shared ExcCode constants for the exception-code pipeline
package exc_pipe_pkg;

  localparam int EXC_W = 5;

  typedef enum logic [EXC_W-1:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

endpackage

// File: rtl/exc_pipe_if.sv
// rtl/exc_pipe_if.sv - injection/stall/flush inputs and per-stage taps of exc_pipe
interface exc_pipe_if #(
  parameter int NSTAGE = 4,
  parameter int CODE_W = 5,
  parameter int CNT_W  = 16
);

  logic [NSTAGE-1:0]        inj_valid;
  logic [NSTAGE*CODE_W-1:0] inj_code;
  logic [NSTAGE-1:0]        stall;
  logic                     flush;
  logic [NSTAGE-1:0]        stg_valid;
  logic [NSTAGE*CODE_W-1:0] stg_code;
  logic                     out_valid;
  logic [CODE_W-1:0]        out_code;
  logic [CNT_W-1:0]         exc_cnt;

  modport master (
    output inj_valid, inj_code, stall, flush,
    input  stg_valid, stg_code, out_valid, out_code, exc_cnt
  );

  modport slave (
    input  inj_valid, inj_code, stall, flush,
    output stg_valid, stg_code, out_valid, out_code, exc_cnt
  );

endinterface

// File: rtl/exc_pipe_stage.sv
// rtl/exc_pipe_stage.sv - one exception-code register with merge mux, hold and bubble
module exc_pipe_stage
  import exc_pipe_pkg::*;
#(
  parameter int                CODE_W   = EXC_W,
  parameter logic [CODE_W-1:0] INT_CODE = CODE_W'(EXC_INT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              hold,
  input  logic              bubble,
  input  logic              prev_valid,
  input  logic [CODE_W-1:0] prev_code,
  input  logic              inj_valid,
  input  logic [CODE_W-1:0] inj_code,
  output logic              valid,
  output logic [CODE_W-1:0] code
);

  logic              m_valid;
  logic [CODE_W-1:0] m_code;

  // The older instruction's code always beats a fresh detection in this stage.
  always_comb begin
    m_valid = prev_valid | inj_valid;
    m_code  = INT_CODE;
    if (prev_valid) begin
      m_code = prev_code;
    end else if (inj_valid) begin
      m_code = inj_code;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      code  <= INT_CODE;
    end else if (flush) begin
      valid <= 1'b0;
      code  <= INT_CODE;
    end else if (hold) begin
      valid <= valid;
      code  <= code;
    end else if (bubble) begin
      valid <= 1'b0;
      code  <= INT_CODE;
    end else begin
      valid <= m_valid;
      code  <= m_code;
    end
  end

endmodule

// File: rtl/exc_pipe.sv
// rtl/exc_pipe.sv - exception-code pipeline top; EXC_PIPE_CNT_EN adds a committed-exception counter
module exc_pipe
  import exc_pipe_pkg::*;
#(
  parameter int                CODE_W   = EXC_W,
  parameter int                NSTAGE   = 4,
  parameter logic [CODE_W-1:0] INT_CODE = CODE_W'(EXC_INT),
  parameter int                CNT_W    = 16
) (
  input  logic       clk,
  input  logic       reset,
  exc_pipe_if.slave  bus
);

  logic [NSTAGE-1:0]        hold;
  logic [NSTAGE-1:0]        bubble;
  logic [NSTAGE-1:0]        v;
  logic [NSTAGE*CODE_W-1:0] c;

  // A stall anywhere downstream freezes every earlier register.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    hold = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      acc     = acc | bus.stall[i];
      hold[i] = acc;
    end
  end

  // The first register behind the frozen section receives a bubble.
  always_comb begin
    bubble = '0;
    for (int i = 1; i < NSTAGE; i++) begin
      bubble[i] = hold[i-1] & ~hold[i];
    end
  end

  genvar g;
  generate
    for (g = 0; g < NSTAGE; g++) begin : g_stage
      logic              prev_valid;
      logic [CODE_W-1:0] prev_code;

      if (g == 0) begin : g_head
        assign prev_valid = 1'b0;
        assign prev_code  = INT_CODE;
      end else begin : g_body
        assign prev_valid = v[g-1];
        assign prev_code  = c[(g-1)*CODE_W +: CODE_W];
      end

      exc_pipe_stage #(
        .CODE_W   (CODE_W),
        .INT_CODE (INT_CODE)
      ) u_stage (
        .clk        (clk),
        .reset      (reset),
        .flush      (bus.flush),
        .hold       (hold[g]),
        .bubble     (bubble[g]),
        .prev_valid (prev_valid),
        .prev_code  (prev_code),
        .inj_valid  (bus.inj_valid[g]),
        .inj_code   (bus.inj_code[g*CODE_W +: CODE_W]),
        .valid      (v[g]),
        .code       (c[g*CODE_W +: CODE_W])
      );
    end
  endgenerate

  assign bus.stg_valid = v;
  assign bus.stg_code  = c;
  assign bus.out_valid = v[NSTAGE-1];
  assign bus.out_code  = c[(NSTAGE-1)*CODE_W +: CODE_W];

`ifdef EXC_PIPE_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic             commit;

  // Mirrors the last register's load condition with a valid merge result.
  assign commit = ~bus.flush & ~hold[NSTAGE-1] & ~bubble[NSTAGE-1] &
                  (v[NSTAGE-2] | bus.inj_valid[NSTAGE-1]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (commit && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign bus.exc_cnt = cnt;
`else
  assign bus.exc_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_exc_pipe.sv
// tb/tb_exc_pipe.sv - directed self-checking bench for exc_pipe
module tb_exc_pipe;

  localparam int NSTAGE = 4;
  localparam int CODE_W = 5;
  localparam int CNT_W  = 2;
`ifdef EXC_PIPE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  exc_pipe_if #(.NSTAGE(NSTAGE), .CODE_W(CODE_W), .CNT_W(CNT_W)) bus ();

  exc_pipe #(
    .CODE_W   (CODE_W),
    .NSTAGE   (NSTAGE),
    .INT_CODE (5'd0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inj_valid = '0;
    bus.inj_code  = '0;
    bus.stall     = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic chk_pipe(input string name, input logic [3:0] ev, input logic [19:0] ec);
    n_cmp++;
    if (bus.stg_valid !== ev) begin
      n_bad++;
      $display("FAIL %s_valid: got %b want %b", name, bus.stg_valid, ev);
    end
    n_cmp++;
    if (bus.stg_code !== ec) begin
      n_bad++;
      $display("FAIL %s_code: got %h want %h", name, bus.stg_code, ec);
    end
  endtask

  task automatic test_reset();
    logic [1:0] ecnt;
    idle_inputs();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk_pipe("reset_init", 4'b0000, 20'h0);
    #3 reset = 1'b1;
    bus.inj_valid = 4'b1111;
    bus.inj_code  = {5'd12, 5'd12, 5'd12, 5'd12};
    tick();
    chk_pipe("fill12", 4'b1111, {5'd12, 5'd12, 5'd12, 5'd12});
    ecnt = CNT_ON ? 2'd1 : 2'd0;
    n_cmp++;
    if (bus.exc_cnt !== ecnt) begin
      n_bad++;
      $display("FAIL cnt_before_reset: got %0d want %0d", bus.exc_cnt, ecnt);
    end
    #2 reset = 1'b0;
    #1;
    chk_pipe("async_reset", 4'b0000, 20'h0);
    n_cmp++;
    if (bus.exc_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL cnt_reset: got %0d want 0", bus.exc_cnt);
    end
    idle_inputs();
    #1 reset = 1'b1;
  endtask

  task automatic test_propagation();
    bus.inj_valid = 4'b0001;
    bus.inj_code  = {5'd0, 5'd0, 5'd0, 5'd4};
    tick();
    idle_inputs();
    chk_pipe("prop_e1", 4'b0001, {5'd0, 5'd0, 5'd0, 5'd4});
    tick();
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL prop_e3_out_valid: got %b want 0", bus.out_valid);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_code !== 5'd4) begin
      n_bad++;
      $display("FAIL prop_e4_out: got %b/%0d want 1/4", bus.out_valid, bus.out_code);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_code !== 5'd0) begin
      n_bad++;
      $display("FAIL prop_e5_out: got %b/%0d want 0/0", bus.out_valid, bus.out_code);
    end
    bus.inj_valid = 4'b1000;
    bus.inj_code  = {5'd10, 5'd0, 5'd0, 5'd0};
    tick();
    idle_inputs();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_code !== 5'd10) begin
      n_bad++;
      $display("FAIL prop_last_stage: got %b/%0d want 1/10", bus.out_valid, bus.out_code);
    end
    tick();
  endtask

  task automatic test_oldest_wins();
    bus.inj_valid = 4'b0001;
    bus.inj_code  = {5'd0, 5'd0, 5'd0, 5'd4};
    tick();
    idle_inputs();
    tick();
    bus.inj_valid = 4'b0100;
    bus.inj_code  = {5'd0, 5'd12, 5'd0, 5'd0};
    tick();
    idle_inputs();
    chk_pipe("oldest_e3", 4'b0100, {5'd0, 5'd4, 5'd0, 5'd0});
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_code !== 5'd4) begin
      n_bad++;
      $display("FAIL oldest_out: got %b/%0d want 1/4", bus.out_valid, bus.out_code);
    end
    tick();
    chk_pipe("oldest_drain", 4'b0000, 20'h0);
  endtask

  task automatic test_stall_bubble();
    bus.inj_valid = 4'b1111;
    bus.inj_code  = {5'd12, 5'd10, 5'd5, 5'd4};
    tick();
    chk_pipe("stall_fill", 4'b1111, {5'd12, 5'd10, 5'd5, 5'd4});
    bus.inj_valid = 4'b0001;
    bus.inj_code  = {5'd0, 5'd0, 5'd0, 5'd10};
    bus.stall     = 4'b0010;
    tick();
    chk_pipe("stall_e1", 4'b1011, {5'd10, 5'd0, 5'd5, 5'd4});
    tick();
    chk_pipe("stall_e2", 4'b0011, {5'd0, 5'd0, 5'd5, 5'd4});
    idle_inputs();
    tick();
    chk_pipe("stall_release", 4'b0110, {5'd0, 5'd5, 5'd4, 5'd0});
  endtask

  task automatic test_flush();
    bus.flush     = 1'b1;
    bus.stall     = 4'b1111;
    bus.inj_valid = 4'b1111;
    bus.inj_code  = {5'd12, 5'd12, 5'd12, 5'd12};
    tick();
    idle_inputs();
    chk_pipe("flush", 4'b0000, 20'h0);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_out_valid: got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_counter();
    logic [1:0] e2;
    logic [1:0] e3;
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    n_cmp++;
    if (bus.exc_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL cnt_clear: got %0d want 0", bus.exc_cnt);
    end
    e2 = CNT_ON ? 2'd2 : 2'd0;
    e3 = CNT_ON ? 2'd3 : 2'd0;
    bus.inj_valid = 4'b1000;
    bus.inj_code  = {5'd5, 5'd0, 5'd0, 5'd0};
    tick();
    tick();
    n_cmp++;
    if (bus.exc_cnt !== e2) begin
      n_bad++;
      $display("FAIL cnt_two: got %0d want %0d", bus.exc_cnt, e2);
    end
    tick();
    n_cmp++;
    if (bus.exc_cnt !== e3) begin
      n_bad++;
      $display("FAIL cnt_three: got %0d want %0d", bus.exc_cnt, e3);
    end
    tick();
    idle_inputs();
    n_cmp++;
    if (bus.exc_cnt !== e3) begin
      n_bad++;
      $display("FAIL cnt_saturate: got %0d want %0d", bus.exc_cnt, e3);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_propagation();
    test_oldest_wins();
    test_stall_bubble();
    test_flush();
    test_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
